// File: rtl/div_tick_pwm_if.sv
// Configuration port for div_tick_pwm: a valid/ready transfer of rate, period and duty.
// The master offers a setting; the slave (the PWM block) accepts it when ready is high.
interface div_tick_pwm_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_rate;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_rate,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_rate,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/div_tick_pwm.sv
// Turns the divider's div2/div4 levels into clk-domain tick enables and drives a PWM
// generator from them; new settings take effect only at period boundaries or in IDLE.
module div_tick_pwm #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          div2_i,
  input  logic          div4_i,
  input  logic          enable_i,
  div_tick_pwm_if.slave cfg_if,
  output logic          pwm_o,
  output logic          tick_o,
  output logic          period_done_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             div2_prev_q;
  logic             div4_prev_q;
  logic             pwm_q;
  logic             tick_q;
  logic             done_q;

  // active configuration
  logic [1:0]       rate_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] duty_q;

  // shadow configuration waiting for a safe point to be applied
  logic [1:0]       sh_rate_q;
  logic [WIDTH-1:0] sh_period_q;
  logic [WIDTH-1:0] sh_duty_q;
  logic             pending_q;

  logic             accept_c;
  logic             tick_c;
  logic             wrap_c;
  logic             apply_c;
  logic [WIDTH-1:0] last_cnt_c;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] duty_d;

  assign cfg_if.cfg_ready = ~pending_q;
  assign accept_c         = cfg_if.cfg_valid & ~pending_q;

  always_comb begin
    tick_c = 1'b0;
    case (rate_q)
      2'b00:   tick_c = 1'b1;
      2'b01:   tick_c = div2_i & ~div2_prev_q;
      default: tick_c = div4_i & ~div4_prev_q;
    endcase
  end

  // A period of 0 behaves as 1, so the last count value is 0 in both cases.
  assign last_cnt_c = (period_q == '0) ? '0 : period_q - 1'b1;
  assign wrap_c     = (cnt_q == last_cnt_c);
  assign cnt_d      = wrap_c ? '0 : cnt_q + 1'b1;

  // The shadow becomes active in IDLE, on leaving RUN, or at a counted wrap.
  assign apply_c = pending_q &
                   ((state_q == ST_IDLE) | ~enable_i | (tick_c & wrap_c));

  // Duty that is in force after this edge, used for the registered PWM compare.
  assign duty_d = apply_c ? sh_duty_q : duty_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div2_prev_q <= 1'b0;
      div4_prev_q <= 1'b0;
      pwm_q       <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      rate_q      <= 2'b00;
      period_q    <= '1;
      duty_q      <= '0;
      sh_rate_q   <= 2'b00;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      pending_q   <= 1'b0;
    end else begin
      div2_prev_q <= div2_i;
      div4_prev_q <= div4_i;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;

      if (accept_c) begin
        sh_rate_q   <= cfg_if.cfg_rate;
        sh_period_q <= cfg_if.cfg_period;
        sh_duty_q   <= cfg_if.cfg_duty;
      end

      if (apply_c) begin
        rate_q   <= sh_rate_q;
        period_q <= sh_period_q;
        duty_q   <= sh_duty_q;
      end

      // accept_c needs pending_q low and apply_c needs it high, so they never collide.
      pending_q <= accept_c | (pending_q & ~apply_c);

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (enable_i) begin
            state_q <= ST_RUN;
            pwm_q   <= (duty_d != '0);
          end else begin
            pwm_q <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!enable_i) begin
            // Leaving wins over a tick or wrap in the same cycle.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
          end else if (tick_c) begin
            cnt_q  <= cnt_d;
            pwm_q  <= (cnt_d < duty_d);
            tick_q <= 1'b1;
            done_q <= wrap_c;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          pwm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_o         = pwm_q;
  assign tick_o        = tick_q;
  assign period_done_o = done_q;

endmodule

// File: tb/tb_div_tick_pwm.sv
// Directed bench for div_tick_pwm: a free-running divider model feeds div2/div4 and each
// PWM period is measured between period_done pulses against hand-computed lengths.
module tb_div_tick_pwm;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       div2 = 1'b0;
  logic       div4 = 1'b0;
  logic       enable = 1'b0;
  logic       pwm;
  logic       tick;
  logic       done;
  logic [1:0] dc = 2'd0;

  int errors = 0;
  int checks = 0;

  div_tick_pwm_if #(.WIDTH(WIDTH)) cfg_if ();

  div_tick_pwm #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .div2_i        (div2),
    .div4_i        (div4),
    .enable_i      (enable),
    .cfg_if        (cfg_if),
    .pwm_o         (pwm),
    .tick_o        (tick),
    .period_done_o (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample point is 1 time unit after the edge, then the divider advances.
  task automatic step();
    @(posedge clk);
    #1;
    dc   = dc + 2'd1;
    div2 = dc[0];
    div4 = dc[1];
  endtask

  task automatic wait_done(input string tag, output logic ready_before);
    int   n  = 0;
    logic rb = 1'bx;
    do begin
      rb = cfg_if.cfg_ready;
      step();
      n++;
    end while (!done && n < 2000);
    ready_before = rb;
    check(tag, done, 1);
  endtask

  // Counts from the current period_done sample up to and including the next one.
  task automatic measure_period(output int len, output int high, output int ticks);
    len   = 0;
    high  = 0;
    ticks = 0;
    do begin
      step();
      len++;
      if (pwm)  high++;
      if (tick) ticks++;
    end while (!done && len < 2000);
  endtask

  task automatic send_cfg(input logic [1:0] rate, input int n, input int d);
    int w = 0;
    while (!cfg_if.cfg_ready && w < 1000) begin
      step();
      w++;
    end
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_rate   = rate;
    cfg_if.cfg_period = n[WIDTH-1:0];
    cfg_if.cfg_duty   = d[WIDTH-1:0];
    $display("cfg rate=%0d period=%0d duty=%0d at %0t", rate, n, d, $time);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    int   len;
    int   high;
    int   ticks;
    logic rb;

    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_rate   = 2'b00;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_pwm", pwm, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);

    // Default config: N=255, D=0, tick every clk
    enable = 1'b1;
    wait_done("def_sync", rb);
    measure_period(len, high, ticks);
    $display("period default len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("def_len", len, 255);
    check("def_high", high, 0);
    check("def_ticks", ticks, 255);

    // Rate 01, N=4, D=1 loaded in IDLE
    enable = 1'b0;
    step();
    check("idle_pwm", pwm, 0);
    check("idle_tick", tick, 0);
    send_cfg(2'b01, 4, 1);
    check("idle_rdy_lo", cfg_if.cfg_ready, 0);
    step();
    check("idle_rdy_hi", cfg_if.cfg_ready, 1);
    enable = 1'b1;
    wait_done("r01_sync", rb);
    measure_period(len, high, ticks);
    $display("period r01 len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("r01_len", len, 8);
    check("r01_high", high, 2);
    check("r01_ticks", ticks, 4);

    // Rate 10, N=3, D=2 loaded while running
    send_cfg(2'b10, 3, 2);
    check("run_rdy_lo", cfg_if.cfg_ready, 0);
    wait_done("r10_apply", rb);
    check("run_rdy_before_wrap", rb, 0);
    check("run_rdy_after_wrap", cfg_if.cfg_ready, 1);
    wait_done("r10_sync", rb);
    measure_period(len, high, ticks);
    $display("period r10 len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("r10_len", len, 12);
    check("r10_high", high, 8);
    check("r10_ticks", ticks, 3);

    // N=5, D=5 offered mid-period: constant high from the next wrap
    repeat (3) step();
    send_cfg(2'b10, 5, 5);
    check("n5_rdy_lo", cfg_if.cfg_ready, 0);
    wait_done("n5_apply", rb);
    check("n5_rdy_before_wrap", rb, 0);
    check("n5_rdy_after_wrap", cfg_if.cfg_ready, 1);
    check("n5_pwm_at_wrap", pwm, 1);
    measure_period(len, high, ticks);
    $display("period n5 len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("n5_len", len, 20);
    check("n5_high", high, 20);
    check("n5_ticks", ticks, 5);

    // N=6, D=3 accepted on the wrap edge itself: old setting runs one more period
    repeat (19) step();
    send_cfg(2'b10, 6, 3);
    check("wrapacc_done", done, 1);
    check("wrapacc_rdy", cfg_if.cfg_ready, 0);
    measure_period(len, high, ticks);
    $display("period wrapacc_old len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("wrapacc_old_len", len, 20);
    check("wrapacc_old_high", high, 20);
    measure_period(len, high, ticks);
    $display("period wrapacc_new len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("wrapacc_new_len", len, 24);
    check("wrapacc_new_high", high, 12);
    check("wrapacc_new_ticks", ticks, 6);

    // N=0 behaves as N=1: wrap on every tick, output low
    enable = 1'b0;
    step();
    send_cfg(2'b00, 0, 0);
    step();
    enable = 1'b1;
    wait_done("n0_sync", rb);
    measure_period(len, high, ticks);
    $display("period n0 len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("n0_len", len, 1);
    check("n0_high", high, 0);
    check("n0_ticks", ticks, 1);

    // Reset mid-period with a config still pending
    send_cfg(2'b00, 50, 20);
    wait_done("n50_apply", rb);
    measure_period(len, high, ticks);
    $display("period n50 len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("n50_len", len, 50);
    check("n50_high", high, 20);
    repeat (5) step();
    send_cfg(2'b00, 3, 1);
    check("pre_rst_rdy", cfg_if.cfg_ready, 0);
    step();
    check("pre_rst_pwm", pwm, 1);
    check("pre_rst_tick", tick, 1);
    reset = 1'b1;
    #2;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ready", cfg_if.cfg_ready, 1);
    step();
    step();
    reset = 1'b0;
    wait_done("post_rst_sync", rb);
    measure_period(len, high, ticks);
    $display("period post_rst len=%0d high=%0d ticks=%0d", len, high, ticks);
    check("post_rst_len", len, 255);
    check("post_rst_high", high, 0);
    check("post_rst_ticks", ticks, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
